// File: rtl/onehot_check_pkg.sv
// Shared constants and helpers for the one-hot select checker.
// The optional sticky error flag is built when ONEHOT_CHECK_STICKY_EN is defined.
package onehot_check_pkg;

   localparam int unsigned ADDR_WIDTH_DEFAULT = 32'd5;
   localparam int unsigned OH_MAX_W           = 32'd1024;

   // Binary-to-one-hot; addresses at or beyond width decode to all-zero.
   function automatic logic [OH_MAX_W-1:0] onehot_enc(input logic [31:0] addr,
                                                       input int unsigned width);
      logic [OH_MAX_W-1:0] one_v;
      one_v = {{(OH_MAX_W-1){1'b0}}, 1'b1};
      if (addr < width) begin
         return one_v << addr;
      end else begin
         return {OH_MAX_W{1'b0}};
      end
   endfunction

   function automatic bit params_legal(input int unsigned addr_width,
                                       input int unsigned oh_width,
                                       input bit          addr_check,
                                       input bit          enable_check);
      return (addr_width >= 32'd1) && (addr_width <= 32'd31) &&
             (oh_width >= 32'd2) && (oh_width <= OH_MAX_W) &&
             (oh_width <= (32'd1 << addr_width)) &&
             (enable_check || !addr_check);
   endfunction

endpackage

// File: rtl/onehot_check_if.sv
// Select-vector bundle between the address decoder side and the checker.
interface onehot_check_if
   import onehot_check_pkg::*;
#(
   parameter int unsigned AddrWidth   = ADDR_WIDTH_DEFAULT,
   parameter int unsigned OneHotWidth = 32'd1 << AddrWidth
);

   logic [OneHotWidth-1:0] oh_i;
   logic [AddrWidth-1:0]   addr_i;
   logic                   en_i;
   logic                   err_o;

   modport master (output oh_i, output addr_i, output en_i, input err_o);
   modport slave  (input oh_i, input addr_i, input en_i, output err_o);

endinterface

// File: rtl/onehot_check_buf.sv
// Keep-buffer isolating the checker's copy of the select vector so
// synthesis cannot share logic between checker and decoder.
module onehot_buf #(
   parameter int unsigned Width = 32'd32
) (
   input  logic [Width-1:0] in_i,
   output logic [Width-1:0] out_o
);

   (* keep = "true", dont_touch = "true" *) logic [Width-1:0] buf_s;

   assign buf_s = in_i;
   assign out_o = buf_s;

endmodule

// File: rtl/onehot_check.sv
// Combinational fault detector for one-hot select vectors (multi-hot,
// enable mismatch, address mismatch). ONEHOT_CHECK_STICKY_EN adds err_sticky_o.
module onehot_check
   import onehot_check_pkg::*;
#(
   parameter int unsigned AddrWidth   = ADDR_WIDTH_DEFAULT,
   parameter int unsigned OneHotWidth = 32'd1 << AddrWidth,
   parameter bit          AddrCheck   = 1'b1,
   parameter bit          EnableCheck = 1'b1,
   parameter bit          StrictCheck = 1'b1
) (
   input  logic           clk_int,
   input  logic           rst_ni,
   onehot_check_if.slave  bus
`ifdef ONEHOT_CHECK_STICKY_EN
   ,
   output logic           err_sticky_o
`endif
);

   localparam int unsigned Levels = $clog2(OneHotWidth);
   localparam int unsigned NLeaf  = 32'd1 << Levels;

   if (!params_legal(AddrWidth, OneHotWidth, AddrCheck, EnableCheck)) begin : g_param_err
      $error("onehot_check: illegal parameter combination");
   end

   logic [OneHotWidth-1:0] oh_buf_s;
   logic [NLeaf-1:0]       leaf_s;
   logic [OneHotWidth-1:0] addr_mask_s;
   logic                   any_s;
   logic                   multi_s;
   logic                   enable_err_s;
   logic                   addr_err_s;
   logic                   err_s;

   onehot_buf #(.Width(OneHotWidth)) u_buf (
      .in_i  (bus.oh_i),
      .out_o (oh_buf_s)
   );

   assign leaf_s = NLeaf'(oh_buf_s);

   // Pairwise tree: each node carries "any set" and "two or more set".
   for (genvar l = 0; l <= Levels; l++) begin : g_lvl
      localparam int unsigned W = NLeaf >> l;
      logic [W-1:0] any_v;
      logic [W-1:0] multi_v;
      if (l == 0) begin : g_leaf
         assign any_v   = leaf_s;
         assign multi_v = {W{1'b0}};
      end else begin : g_node
         for (genvar n = 0; n < W; n++) begin : g_n
            assign any_v[n]   = g_lvl[l-1].any_v[2*n] | g_lvl[l-1].any_v[2*n+1];
            assign multi_v[n] = g_lvl[l-1].multi_v[2*n] | g_lvl[l-1].multi_v[2*n+1] |
                                (g_lvl[l-1].any_v[2*n] & g_lvl[l-1].any_v[2*n+1]);
         end
      end
   end

   assign any_s       = g_lvl[Levels].any_v[0];
   assign multi_s     = g_lvl[Levels].multi_v[0];
   assign addr_mask_s = OneHotWidth'(onehot_enc(32'(bus.addr_i), OneHotWidth));

   // Enable and address consistency terms.
   always_comb begin
      enable_err_s = 1'b0;
      addr_err_s   = 1'b0;
      if (!EnableCheck) begin
         enable_err_s = 1'b0;
      end else if (StrictCheck) begin
         enable_err_s = bus.en_i ^ any_s;
      end else begin
         enable_err_s = ~bus.en_i & any_s;
      end
      if (AddrCheck) begin
         addr_err_s = any_s & ~(|(oh_buf_s & addr_mask_s));
      end else begin
         addr_err_s = 1'b0;
      end
   end

   assign err_s      = multi_s | enable_err_s | addr_err_s;
   assign bus.err_o  = err_s;

`ifdef ONEHOT_CHECK_STICKY_EN
   logic sticky_d;
   logic sticky_q;

   assign sticky_d = sticky_q | err_s;

   // Set-only record of any error seen since the last reset.
   always_ff @(posedge clk_int or negedge rst_ni) begin
      if (!rst_ni) begin
         sticky_q <= 1'b0;
      end else begin
         sticky_q <= sticky_d;
      end
   end

   assign err_sticky_o = sticky_q;
`else
   logic unused_clk_rst_s;
   assign unused_clk_rst_s = clk_int ^ rst_ni;
`endif

endmodule

// File: tb/tb_onehot_check.sv
// Scoreboard bench for onehot_check: strict and non-strict instances driven
// with directed and random vectors, checked against a counting reference model.
module tb_onehot_check;

   localparam int AW = 5;
   localparam int OW = 32;

   logic clk_int = 1'b0;
   logic rst_ni  = 1'b0;
   always #5 clk_int = ~clk_int;

   onehot_check_if #(.AddrWidth(AW), .OneHotWidth(OW)) bus_s ();
   onehot_check_if #(.AddrWidth(AW), .OneHotWidth(OW)) bus_l ();

`ifdef ONEHOT_CHECK_STICKY_EN
   logic sticky_s;
   logic sticky_l;
   logic sticky_model_s;
   logic sticky_model_l;
`endif

   onehot_check #(.AddrWidth(AW), .OneHotWidth(OW), .AddrCheck(1'b1),
                  .EnableCheck(1'b1), .StrictCheck(1'b1)) dut_s (
      .clk_int (clk_int),
      .rst_ni  (rst_ni),
      .bus     (bus_s)
`ifdef ONEHOT_CHECK_STICKY_EN
      ,
      .err_sticky_o (sticky_s)
`endif
   );

   onehot_check #(.AddrWidth(AW), .OneHotWidth(OW), .AddrCheck(1'b1),
                  .EnableCheck(1'b1), .StrictCheck(1'b0)) dut_l (
      .clk_int (clk_int),
      .rst_ni  (rst_ni),
      .bus     (bus_l)
`ifdef ONEHOT_CHECK_STICKY_EN
      ,
      .err_sticky_o (sticky_l)
`endif
   );

   typedef struct {
      int   tag;
      logic exp_s;
      logic exp_l;
   } item_t;

   item_t sb_q[$];
   int    n_pass  = 0;
   int    n_total = 0;

   // Reference: count set bits and apply the rules directly.
   function automatic logic ref_err(logic [OW-1:0] oh, int addr, logic en, bit strict);
      int cnt = 0;
      bit any, multi, en_err, a_err;
      for (int i = 0; i < OW; i++) begin
         if (oh[i]) cnt++;
      end
      any    = (cnt > 0);
      multi  = (cnt > 1);
      en_err = strict ? (en != any) : (!en && any);
      a_err  = any && !((addr < OW) && oh[addr]);
      return multi || en_err || a_err;
   endfunction

   task automatic chk(string nm, int tag, logic act, logic exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s tag=%0d got=%0b expected=%0b", nm, tag, act, exp);
      end
   endtask

   task automatic issue(int tag, logic [OW-1:0] oh, logic [AW-1:0] addr, logic en);
      item_t it;
      @(posedge clk_int);
      #1;
      bus_s.oh_i = oh;  bus_s.addr_i = addr;  bus_s.en_i = en;
      bus_l.oh_i = oh;  bus_l.addr_i = addr;  bus_l.en_i = en;
      it.tag   = tag;
      it.exp_s = ref_err(oh, int'(addr), en, 1'b1);
      it.exp_l = ref_err(oh, int'(addr), en, 1'b0);
      sb_q.push_back(it);
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && sb_q.size() != 0; k++) begin
         @(negedge clk_int);
      end
      if (sb_q.size() != 0) begin
         n_total++;
         $display("FAIL drain: %0d items left, required 0", sb_q.size());
      end
   endtask

   // Monitor: compare DUT outputs with the oldest expected item.
   always @(negedge clk_int) begin
      item_t it;
      if (sb_q.size() != 0) begin
         it = sb_q.pop_front();
         chk("err_strict", it.tag, bus_s.err_o, it.exp_s);
         chk("err_loose",  it.tag, bus_l.err_o, it.exp_l);
`ifdef ONEHOT_CHECK_STICKY_EN
         chk("sticky_strict", it.tag, sticky_s, sticky_model_s);
         chk("sticky_loose",  it.tag, sticky_l, sticky_model_l);
`endif
      end
   end

`ifdef ONEHOT_CHECK_STICKY_EN
   // Sticky model: any erroneous sample at a clock edge latches until reset.
   always @(posedge clk_int or negedge rst_ni) begin
      if (!rst_ni) begin
         sticky_model_s <= 1'b0;
         sticky_model_l <= 1'b0;
      end else begin
         if (ref_err(bus_s.oh_i, int'(bus_s.addr_i), bus_s.en_i, 1'b1)) sticky_model_s <= 1'b1;
         if (ref_err(bus_l.oh_i, int'(bus_l.addr_i), bus_l.en_i, 1'b0)) sticky_model_l <= 1'b1;
      end
   end
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      int r2;
      logic [OW-1:0] oh;
      logic [AW-1:0] addr;
      bus_s.oh_i = '0; bus_s.addr_i = '0; bus_s.en_i = 1'b0;
      bus_l.oh_i = '0; bus_l.addr_i = '0; bus_l.en_i = 1'b0;

      // Inputs are checked while reset is held: err_o ignores reset.
      issue(0, 32'h0000_0000, 5'd0, 1'b0);
      issue(0, 32'h0000_0003, 5'd0, 1'b1);
      @(posedge clk_int);
      #2 rst_ni = 1'b1;

      issue(1, 32'h0000_0100, 5'd8,  1'b1);
      issue(2, 32'h0000_0000, 5'd17, 1'b0);
      issue(3, 32'h0000_0000, 5'd17, 1'b1);
      issue(4, 32'h0000_0003, 5'd0,  1'b1);
      issue(5, 32'h0000_0010, 5'd5,  1'b1);
      issue(6, 32'h0000_0001, 5'd0,  1'b0);
      issue(7, 32'hFFFF_FFFF, 5'd0,  1'b1);
      issue(8, 32'hFFFF_FFFF, 5'd3,  1'b0);
      issue(9, 32'h8000_0000, 5'd31, 1'b1);
      issue(9, 32'h8000_0000, 5'd30, 1'b1);

      for (int i = 0; i < OW; i++) begin
         issue(10, 32'd1 << i, AW'(i), 1'b1);
      end

      for (int i = 0; i < OW; i++) begin
         for (int j = i + 1; j < OW; j++) begin
            issue(11, (32'd1 << i) | (32'd1 << j), AW'($urandom_range(OW - 1)), 1'b1);
         end
      end

      repeat (300) begin
         r  = int'($urandom_range(OW - 1));
         r2 = int'($urandom_range(OW - 1));
         case ($urandom_range(3))
            0:       oh = 32'd1 << r;
            1:       oh = 32'h0000_0000;
            2:       oh = $urandom;
            default: oh = (32'd1 << r) | (32'd1 << r2);
         endcase
         addr = ($urandom_range(1) == 1) ? AW'(r) : AW'($urandom_range(OW - 1));
         issue(12, oh, addr, 1'($urandom_range(1)));
      end
      drain();

`ifdef ONEHOT_CHECK_STICKY_EN
      chk("sticky_after_errors", 20, sticky_s, 1'b1);
      @(posedge clk_int);
      #3 rst_ni = 1'b0;
      #1;
      chk("sticky_async_clear_s", 21, sticky_s, 1'b0);
      chk("sticky_async_clear_l", 21, sticky_l, 1'b0);
      @(posedge clk_int);
      #2 rst_ni = 1'b1;
      issue(22, 32'h0000_0004, 5'd2, 1'b1);
      issue(22, 32'h0000_0004, 5'd2, 1'b1);
      issue(23, 32'h0000_0006, 5'd1, 1'b1);
      issue(24, 32'h0000_0004, 5'd2, 1'b1);
      issue(24, 32'h0000_0004, 5'd2, 1'b1);
      drain();
      chk("sticky_holds", 25, sticky_s, 1'b1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/onehot_check.md
Name: onehot_check

Overview:
- Combinational glitch/fault detector for one-hot select vectors, e.g. register-file write strobes and read selects.
- Flags these faults on a one-hot vector:
  - more than one bit set;
  - vector activity not matching an enable;
  - active bit not matching a reference binary address.
- Sits beside the address decoder. Its input passes through a keep-buffer sub-module so synthesis cannot merge the checker into the decoder.

Parameters:
- AddrWidth, 5, width of addr_i.
- OneHotWidth, 2**AddrWidth, width of oh_i. Legal range 2..2**AddrWidth.
- AddrCheck, 1, enables the address-consistency check. Requires EnableCheck=1; elaboration error otherwise.
- EnableCheck, 1, enables the enable-consistency check.
- StrictCheck, 1, selects the enable rule:
  - 1: en_i must equal OR(oh_i).
  - 0: only "bit set while en_i low" is an error.

Ports:
- clk_int  input  1  clock; used only by the optional sticky register.
- rst_ni  input  1  reset, asynchronous, active-low.
- oh_i  input  OneHotWidth  one-hot vector under check.
- addr_i  input  AddrWidth  binary address the vector must encode.
- en_i  input  1  enable the vector must reflect.
- err_o  output  1  combinational error indication.

Behaviour:
- Internal vector: oh_buf = oh_i passed bit-for-bit through sub-module onehot_buf. onehot_buf is a pure wire, marked keep/dont_touch. All checks below use oh_buf.
- any = OR(oh_buf).
- multi_err: asserted when two or more bits of oh_buf are set.
  - Implement with a balanced OR/"two-or-more" reduction tree (pairwise tree of {any, multi} nodes), not a popcount adder.
- enable_err, when EnableCheck=1:
  - StrictCheck=1: enable_err = en_i XOR any.
  - StrictCheck=0: enable_err = !en_i AND any.
  - EnableCheck=0: enable_err = 0.
- addr_err, when AddrCheck=1:
  - addr_err = any AND NOT oh_buf[addr_i].
  - If addr_i >= OneHotWidth, the indexed bit counts as 0, so any set bit is an error.
  - AddrCheck=0: addr_err = 0.
- err_o = multi_err OR enable_err OR addr_err.
  - Purely combinational, zero-cycle latency.
  - Independent of clk_int/rst_ni. No reset value needed; err_o follows inputs during reset.
- Boundary cases:
  - oh_i all-zero with en_i=0: no error.
  - oh_i all-ones: multi_err asserted, plus addr_err if the addr bit is clear.
  - Combined faults: all applicable error terms assert simultaneously; err_o is a single OR.
  - X/Z on inputs: not specified; the bench drives known values only.
- No state, handshake or FSM in the base configuration.
- Without the optional feature, clk_int and rst_ni are consumed into an unused-signal sink.

Optional Feature:
- Macro: ONEHOT_CHECK_STICKY_EN.
- Defined: adds output err_sticky_o (1 bit).
  - Flop clocked on posedge clk_int, async clear on negedge rst_ni to 0.
  - Sets to 1 on any clock edge where err_o=1. Stays 1 until reset; no other clear path.
  - err_sticky_o rises one cycle after the erroneous sample.
  - Reset asserted mid-operation clears it immediately, regardless of err_o.
  - err_o behaviour is unchanged.
- Undefined: port err_sticky_o absent, no flops, block purely combinational.

Decomposition:
- Package onehot_check_pkg: default widths (ADDR_WIDTH_DEFAULT=5), the function onehot_enc(addr, width) returning 1<<addr, and the parameter-legality assertion helper.
- One sub-module: onehot_buf (Width parameter, in_i/out_o), the synthesis keep-buffer.
- The reduction tree stays inline.

Test Plan (AddrWidth=5, OneHotWidth=32, all checks on, strict):
- Legal vector: oh_i=32'h0000_0100, addr_i=8, en_i=1 -> err_o=0.
- Idle: oh_i=0, en_i=0, addr_i=any -> err_o=0. Then oh_i=0, en_i=1 -> err_o=1 (enable_err).
- Multiple bits: oh_i=32'h0000_0003, addr_i=0, en_i=1 -> err_o=1. Sweep all 496 two-bit patterns -> err_o=1 for each.
- Address mismatch: oh_i=32'h0000_0010, addr_i=5, en_i=1 -> err_o=1. Walking single bit with matching addr over 0..31 -> err_o=0 for each.
- Non-strict (StrictCheck=0): oh_i=0, en_i=1 -> err_o=0. oh_i=32'h1, en_i=0, addr_i=0 -> err_o=1.
- Sticky (macro defined):
  - Reset, then one error cycle -> err_sticky_o=1 from next edge.
  - Legal inputs afterwards -> err_sticky_o stays 1.
  - rst_ni low -> err_sticky_o=0 asynchronously.
